// File: rtl/karatsuba_seq_mul_if.sv
// Operand/product handshake bundle for karatsuba_seq_mul.
// The master side offers operands and consumes products.
interface karatsuba_seq_mul_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/karatsuba_seq_mul.sv
// Sequential unsigned WIDTH x WIDTH multiplier that time-shares one 8x8
// Karatsuba core over all byte-slice partial products.

module karatsuba_mul_8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  logic [3:0] ah, al, bh, bl;
  logic [4:0] sa, sb;
  logic [7:0] z0, z2;
  logic [9:0] zm, z1;

  assign ah = a_i[7:4];
  assign al = a_i[3:0];
  assign bh = b_i[7:4];
  assign bl = b_i[3:0];

  assign z0 = {4'd0, al} * {4'd0, bl};
  assign z2 = {4'd0, ah} * {4'd0, bh};
  assign sa = {1'b0, ah} + {1'b0, al};
  assign sb = {1'b0, bh} + {1'b0, bl};
  assign zm = {5'd0, sa} * {5'd0, sb};
  // Middle term ah*bl + al*bh recovered with one multiply instead of two.
  assign z1 = zm - {2'd0, z2} - {2'd0, z0};

  assign p_o = {z2, 8'd0} + {2'd0, z1, 4'd0} + {8'd0, z0};
endmodule

module karatsuba_seq_mul #(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  karatsuba_seq_mul_if.slave bus
);
  localparam int NS = WIDTH / 8;
  localparam int K  = NS * NS;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [SW-1:0]     i_q, i_d, j_q, j_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;

  logic [7:0]        a_sl, b_sl;
  logic [15:0]       p;
  logic [SW+3:0]     shamt;
  logic [PW-1:0]     term;

  // i/j track k mod NS and k div NS directly so no divider is needed.
  always_comb begin
    a_sl = 8'd0;
    b_sl = 8'd0;
    for (int s = 0; s < NS; s++) begin
      if (i_q == SW'(s)) a_sl = a_q[8*s +: 8];
      if (j_q == SW'(s)) b_sl = b_q[8*s +: 8];
    end
  end

  karatsuba_mul_8 u_core (
    .a_i (a_sl),
    .b_i (b_sl),
    .p_o (p)
  );

  assign shamt = {({1'b0, i_q} + {1'b0, j_q}), 3'b000};
  assign term  = {{(PW-16){1'b0}}, p} << shamt;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          acc_d   = '0;
          k_d     = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + term;
        k_d   = k_q + 1'b1;
        if (i_q == SW'(NS-1)) begin
          i_d = '0;
          j_d = j_q + 1'b1;
        end else begin
          i_d = i_q + 1'b1;
        end
        if (k_q == KW'(K-1)) begin
          k_d     = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // The accumulator is only cleared on accept, so out_p keeps the last product in IDLE.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_p     = acc_q;
endmodule

// File: tb/tb_karatsuba_seq_mul.sv
// Bench for karatsuba_seq_mul: directed vectors at WIDTH=16/32, corner
// sequences (backpressure, mid-op reset) and a randomized regression.
module tb_karatsuba_seq_mul;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  karatsuba_seq_mul_if #(.WIDTH(16)) b16 ();
  karatsuba_seq_mul_if #(.WIDTH(32)) b32 ();

  karatsuba_seq_mul #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
  karatsuba_seq_mul #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (w) begin
      b32.in_valid = v; b32.in_a = a; b32.in_b = b;
    end else begin
      b16.in_valid = v; b16.in_a = a[15:0]; b16.in_b = b[15:0];
    end
  endtask

  function automatic logic rdy(input bit w);
    return w ? b32.in_ready : b16.in_ready;
  endfunction
  function automatic logic vld(input bit w);
    return w ? b32.out_valid : b16.out_valid;
  endfunction
  function automatic logic bsy(input bit w);
    return w ? b32.busy : b16.busy;
  endfunction
  function automatic logic [63:0] outp(input bit w);
    return w ? b32.out_p : {32'd0, b16.out_p};
  endfunction

  task automatic check_reset(input bit w, input string nm);
    check({nm, "_in_ready"}, 64'(rdy(w)), 64'd1);
    check({nm, "_out_valid"}, 64'(vld(w)), 64'd0);
    check({nm, "_busy"}, 64'(bsy(w)), 64'd0);
    check({nm, "_out_p"}, outp(w), 64'd0);
  endtask

  // Offer one operand pair, check latency and product, then check return to IDLE.
  task automatic run_op(input bit w, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string nm);
    int cyc;
    int lat;
    lat = w ? 16 : 4;
    drive(w, 1'b1, a, b);
    cyc = 0;
    while (!rdy(w) && cyc < 50) begin tick(); cyc++; end
    check({nm, "_ready"}, 64'(rdy(w)), 64'd1);
    tick();
    drive(w, 1'b0, ~a, ~b);
    cyc = 0;
    while (!vld(w) && cyc < 40) begin tick(); cyc++; end
    check({nm, "_lat"}, 64'(cyc), 64'(lat));
    check({nm, "_p"}, outp(w), exp);
    tick();
    check({nm, "_vld_drop"}, 64'(vld(w)), 64'd0);
    check({nm, "_idle_rdy"}, 64'(rdy(w)), 64'd1);
  endtask

  initial begin
    logic [63:0] held;
    int          nv;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 32'd0);
    b16.out_ready = 1'b1;
    b32.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #2;
    check_reset(1'b0, "rst16");
    check_reset(1'b1, "rst32");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    tbl[0]  = '{1'b0, 32'h1234, 32'h5678, 64'h06260060};
    tbl[1]  = '{1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001};
    tbl[2]  = '{1'b0, 32'h0000, 32'hBEEF, 64'h00000000};
    tbl[3]  = '{1'b0, 32'h8000, 32'h0002, 64'h00010000};
    tbl[4]  = '{1'b0, 32'h00FF, 32'h00FF, 64'h0000FE01};
    tbl[5]  = '{1'b0, 32'hFF00, 32'hFF00, 64'hFE010000};
    tbl[6]  = '{1'b0, 32'h0001, 32'hABCD, 64'h0000ABCD};
    tbl[7]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    tbl[8]  = '{1'b1, 32'h00010000, 32'h00010000, 64'h0000000100000000};
    tbl[9]  = '{1'b1, 32'h80000000, 32'h00000002, 64'h0000000100000000};
    tbl[10] = '{1'b1, 32'h000000FF, 32'h01000000, 64'h00000000FF000000};
    tbl[11] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF};

    foreach (tbl[n]) run_op(tbl[n].w, tbl[n].a, tbl[n].b, tbl[n].p, $sformatf("vec%0d", n));

    // Backpressure: product held, further offers ignored.
    b16.out_ready = 1'b0;
    drive(1'b0, 1'b1, 32'h00FF, 32'h0101);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    nv = 0;
    while (!vld(1'b0) && nv < 40) begin tick(); nv++; end
    check("bp_lat", 64'(nv), 64'd4);
    held = outp(1'b0);
    check("bp_p", held, 64'h0000FFFF);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_vld%0d", c), 64'(vld(1'b0)), 64'd1);
      check($sformatf("bp_hold%0d", c), outp(1'b0), 64'h0000FFFF);
      check($sformatf("bp_rdy%0d", c), 64'(rdy(1'b0)), 64'd0);
      drive(1'b0, c[0], 32'h1111, 32'h2222);
      tick();
    end
    // Offer together with out_ready in DONE: taken only in the following IDLE cycle.
    drive(1'b0, 1'b1, 32'h0007, 32'h0009);
    b16.out_ready = 1'b1;
    tick();
    check("sim_vld_drop", 64'(vld(1'b0)), 64'd0);
    check("sim_not_taken", 64'(rdy(1'b0)), 64'd1);
    tick();
    check("sim_taken", 64'(bsy(1'b0)), 64'd1);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    nv = 0;
    while (!vld(1'b0) && nv < 40) begin tick(); nv++; end
    check("sim_p", outp(1'b0), 64'h3F);
    tick();

    // Reset in the middle of CALC.
    drive(1'b0, 1'b1, 32'hABCD, 32'h1234);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check("mid_busy", 64'(bsy(1'b0)), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset(1'b0, "mid_rst");
    tick();
    tick();
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      if (vld(1'b0)) nv++;
      tick();
    end
    check("mid_no_vld", 64'(nv), 64'd0);
    run_op(1'b0, 32'h0003, 32'h0005, 64'h0000000F, "post_rst");

    // Randomized regression against a product queue.
    begin
      logic [63:0] q[$];
      logic [15:0] ra, rb;
      bit          acc;
      int          sent, got, cyc;
      sent = 0; got = 0; cyc = 0;
      ra = 16'd0; rb = 16'd0;
      b16.in_valid = 1'b0;
      while (got < 1000 && cyc < 60000) begin
        if (!b16.in_valid && sent < 1000 && $urandom_range(0, 2) == 0) begin
          ra = 16'($urandom());
          rb = 16'($urandom());
          b16.in_a = ra;
          b16.in_b = rb;
          b16.in_valid = 1'b1;
        end
        b16.out_ready = ($urandom_range(0, 3) != 0);
        acc = b16.in_valid && b16.in_ready;
        if (acc) begin
          q.push_back(64'(ra) * 64'(rb));
          sent++;
        end
        if (b16.out_valid && b16.out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rand_extra: got 0x%0h expected no product", b16.out_p);
          end else begin
            check($sformatf("rand_p%0d", got), 64'(b16.out_p), q.pop_front());
          end
          got++;
        end
        tick();
        cyc++;
        if (acc) b16.in_valid = 1'b0;
      end
      check("rand_count", 64'(got), 64'd1000);
      check("rand_q_empty", 64'(q.size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
